// File: rtl/mbist_seq_fsm.sv
// mbist_seq_fsm
// MBIST main-control sequencer. Steps the operation/address/stimulus/pattern
// generators through command, read-latency wait, compare and advance phases.
// Memories are tested back-to-back. It logs mismatches into a saturating
// counter and into sticky per-memory fail flags.
//
// Parameters:
//   NUM_MEM  number of memories tested serially (1..16)
//   RD_LAT   memory read latency in cycles (1..7)
//   ERR_W    error counter width
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   bist_run              level: high runs the test, low aborts to idle
//   stop_on_err           1 = finish on first mismatch, 0 = log and continue
//   bist_error            compare mismatch (looked at only in the compare cycle)
//   op_reverse, last_*    generator status (looked at only in the compare cycle)
//   cmd_phase, cmp_phase  memory command / compare cycle markers
//   run_op/addr/sti/pat   generator advance pulses
//   mem_next              restart generators for the next memory
//   mem_sel               index of the memory under test
//   bist_done             test finished (held while bist_run stays high)
//   err_cnt               saturating mismatch count
//   mem_fail              sticky per-memory fail flags
module mbist_seq_fsm #(
  parameter int NUM_MEM = 4,
  parameter int RD_LAT  = 1,
  parameter int ERR_W   = 8,
  localparam int MEM_W  = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bist_run,
  input  logic               stop_on_err,
  input  logic               bist_error,
  input  logic               op_reverse,
  input  logic               last_op,
  input  logic               last_addr,
  input  logic               last_sti,
  input  logic               last_pat,
  output logic               cmd_phase,
  output logic               cmp_phase,
  output logic               run_op,
  output logic               run_addr,
  output logic               run_sti,
  output logic               run_pat,
  output logic               mem_next,
  output logic [MEM_W-1:0]   mem_sel,
  output logic               bist_done,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [NUM_MEM-1:0] mem_fail
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WAIT,
    S_CMP,
    S_ADV,
    S_NEXT,
    S_EXIT
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         wait_q, wait_d;
  logic [MEM_W-1:0]   mem_sel_q, mem_sel_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic [NUM_MEM-1:0] mem_fail_q, mem_fail_d;
  logic               cmd_phase_q, cmd_phase_d;
  logic               cmp_phase_q, cmp_phase_d;
  logic               run_op_q, run_op_d;
  logic               run_addr_q, run_addr_d;
  logic               run_sti_q, run_sti_d;
  logic               run_pat_q, run_pat_d;
  logic               mem_next_q, mem_next_d;
  logic               bist_done_q, bist_done_d;
  logic               all_last;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  assign all_last = last_op & last_addr & last_sti & last_pat;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    mem_sel_d  = mem_sel_q;
    err_cnt_d  = err_cnt_q;
    mem_fail_d = mem_fail_q;
    run_op_d   = 1'b0;
    run_addr_d = 1'b0;
    run_sti_d  = 1'b0;
    run_pat_d  = 1'b0;

    // Dropping bist_run overrides everything, including logging in a CMP
    // cycle; the result registers keep their values until the next start.
    if (!bist_run) begin
      state_d = S_IDLE;
      wait_d  = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d    = S_CMD;
          mem_sel_d  = '0;
          err_cnt_d  = '0;
          mem_fail_d = '0;
        end
        S_CMD: begin
          if (RD_LAT == 1) begin
            state_d = S_CMP;
          end else begin
            state_d = S_WAIT;
            wait_d  = 3'(RD_LAT - 1);
          end
        end
        S_WAIT: begin
          // wait_q counts the WAIT cycles still to spend, including this one.
          if (wait_q <= 3'd1) begin
            state_d = S_CMP;
            wait_d  = 3'd0;
          end else begin
            wait_d = wait_q - 3'd1;
          end
        end
        S_CMP: begin
          if (bist_error) begin
            err_cnt_d = sat_inc(err_cnt_q);
            for (int i = 0; i < NUM_MEM; i++) begin
              if (mem_sel_q == MEM_W'(i)) mem_fail_d[i] = 1'b1;
            end
          end
          if (bist_error && stop_on_err) begin
            state_d = S_EXIT;
          end else if (all_last && (mem_sel_q == MEM_W'(NUM_MEM - 1))) begin
            state_d = S_EXIT;
          end else if (all_last) begin
            state_d = S_NEXT;
          end else begin
            // Advance flags are formed from the status seen in this CMP and
            // registered so they appear during ADV.
            state_d    = S_ADV;
            run_op_d   = 1'b1;
            run_addr_d = last_op & ~(last_addr & op_reverse);
            run_sti_d  = last_addr & last_op;
            run_pat_d  = last_addr & last_op & last_sti;
          end
        end
        S_ADV: state_d = S_CMD;
        S_NEXT: begin
          state_d   = S_CMD;
          mem_sel_d = mem_sel_q + MEM_W'(1);
        end
        S_EXIT: state_d = S_EXIT;
        default: state_d = S_IDLE;
      endcase
    end

    // Phase outputs are registered decodes of the next state, so each one is
    // high exactly while the FSM sits in its state.
    cmd_phase_d = (state_d == S_CMD);
    cmp_phase_d = (state_d == S_CMP);
    mem_next_d  = (state_d == S_NEXT);
    bist_done_d = (state_d == S_EXIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wait_q      <= 3'd0;
      mem_sel_q   <= '0;
      err_cnt_q   <= '0;
      mem_fail_q  <= '0;
      cmd_phase_q <= 1'b0;
      cmp_phase_q <= 1'b0;
      run_op_q    <= 1'b0;
      run_addr_q  <= 1'b0;
      run_sti_q   <= 1'b0;
      run_pat_q   <= 1'b0;
      mem_next_q  <= 1'b0;
      bist_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_sel_q   <= mem_sel_d;
      err_cnt_q   <= err_cnt_d;
      mem_fail_q  <= mem_fail_d;
      cmd_phase_q <= cmd_phase_d;
      cmp_phase_q <= cmp_phase_d;
      run_op_q    <= run_op_d;
      run_addr_q  <= run_addr_d;
      run_sti_q   <= run_sti_d;
      run_pat_q   <= run_pat_d;
      mem_next_q  <= mem_next_d;
      bist_done_q <= bist_done_d;
    end
  end

  assign cmd_phase = cmd_phase_q;
  assign cmp_phase = cmp_phase_q;
  assign run_op    = run_op_q;
  assign run_addr  = run_addr_q;
  assign run_sti   = run_sti_q;
  assign run_pat   = run_pat_q;
  assign mem_next  = mem_next_q;
  assign mem_sel   = mem_sel_q;
  assign bist_done = bist_done_q;
  assign err_cnt   = err_cnt_q;
  assign mem_fail  = mem_fail_q;

endmodule
